// File: rtl/text_ram_arbiter_if.sv
// Bus bundle between the two text clients, the arbiter and the single-port text RAM.
// master = client/RAM side, slave = arbiter side.
interface text_ram_arbiter_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 8
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              ram_re, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, ram_re, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, ram_re, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/text_ram_arbiter.sv
// Two-client arbiter for the single-port text RAM: round-robin ties, bounded bursts,
// registered RAM command and tagged fixed-latency read return.
module text_ram_arbiter #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned MAX_BURST  = 4
) (
  input logic             clk,
  input logic             reset,
  text_ram_arbiter_if.slave bus
);

  localparam int unsigned      CNT_W   = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              last_q, last_d;
  logic              pick0, pick1, gnt0_c, gnt1_c;
  logic              rd_issue, wr_issue;

  logic              ram_re_q, ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [RD_LATENCY:0] tag_v_q, tag_id_q;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata_q;

  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    case (state_q)
      S_OWN0: begin
        if (bus.req0 && (!bus.req1 || cnt_q < CNT_MAX)) pick0 = 1'b1;
        else if (bus.req1)                              pick1 = 1'b1;
      end
      S_OWN1: begin
        if (bus.req1 && (!bus.req0 || cnt_q < CNT_MAX)) pick1 = 1'b1;
        else if (bus.req0)                              pick0 = 1'b1;
      end
      default: begin
        // Tie from idle goes to whoever was not served last.
        if (bus.req0 && bus.req1) begin
          pick0 = last_q;
          pick1 = !last_q;
        end else begin
          pick0 = bus.req0;
          pick1 = bus.req1;
        end
      end
    endcase

    gnt0_c  = pick0 & reset;
    gnt1_c  = pick1 & reset;
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    state_d = S_IDLE;
    cnt_d   = '0;
    last_d  = last_q;
    if (gnt0_c) begin
      state_d = S_OWN0;
      last_d  = 1'b0;
      cnt_d   = (state_q == S_OWN0) ? cnt_inc : CNT_ONE;
    end else if (gnt1_c) begin
      state_d = S_OWN1;
      last_d  = 1'b1;
      cnt_d   = (state_q == S_OWN1) ? cnt_inc : CNT_ONE;
    end

    rd_issue = (gnt0_c & ~bus.we0) | (gnt1_c & ~bus.we1);
    wr_issue = (gnt0_c &  bus.we0) | (gnt1_c &  bus.we1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      ram_re_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      ram_re_q <= rd_issue;
      ram_we_q <= wr_issue;
      if (gnt0_c || gnt1_c) begin
        ram_addr_q  <= gnt1_c ? bus.addr1  : bus.addr0;
        ram_wdata_q <= gnt1_c ? bus.wdata1 : bus.wdata0;
      end
    end
  end

  // Tag stage k lines up with RAM cycle k after the grant; the last stage
  // coincides with valid ram_rdata, which is then registered to the client.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_v_q   <= '0;
      tag_id_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      tag_v_q   <= {tag_v_q[RD_LATENCY-1:0], rd_issue};
      tag_id_q  <= {tag_id_q[RD_LATENCY-1:0], gnt1_c};
      rvalid0_q <= tag_v_q[RD_LATENCY] & ~tag_id_q[RD_LATENCY];
      rvalid1_q <= tag_v_q[RD_LATENCY] &  tag_id_q[RD_LATENCY];
      if (tag_v_q[RD_LATENCY]) rdata_q <= bus.ram_rdata;
    end
  end

  assign bus.gnt0      = gnt0_c;
  assign bus.gnt1      = gnt1_c;
  assign bus.ram_re    = ram_re_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Directed bench for text_ram_arbiter: grant/command checks per step, read
// responses checked by a queue-based monitor against a shadow copy of the RAM.
module tb_text_ram_arbiter;
  localparam int unsigned DATA_W     = 24;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned RD_LATENCY = 1;
  localparam int unsigned MAX_BURST  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  text_ram_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  text_ram_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LATENCY(RD_LATENCY), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // RAM model: synchronous, RD_LATENCY cycles from registered ram_re to data.
  logic [DATA_W-1:0] mem [256];
  logic [DATA_W-1:0] rd_pipe [RD_LATENCY];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    for (int i = RD_LATENCY - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= mem[bus.ram_addr];
  end
  assign bus.ram_rdata = rd_pipe[RD_LATENCY-1];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic              id;
    logic [DATA_W-1:0] data;
    int                due;
  } rsp_t;
  rsp_t sbq[$];

  logic [DATA_W-1:0] shadow [256];
  logic              pend_re, pend_we;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string name);
    check({name, ".gnt0"},      32'(bus.gnt0), 0);
    check({name, ".gnt1"},      32'(bus.gnt1), 0);
    check({name, ".ram_re"},    32'(bus.ram_re), 0);
    check({name, ".ram_we"},    32'(bus.ram_we), 0);
    check({name, ".ram_addr"},  32'(bus.ram_addr), 0);
    check({name, ".ram_wdata"}, 32'(bus.ram_wdata), 0);
    check({name, ".rvalid0"},   32'(bus.rvalid0), 0);
    check({name, ".rvalid1"},   32'(bus.rvalid1), 0);
    check({name, ".rdata"},     32'(bus.rdata), 0);
  endtask

  // One clock cycle: drive both clients, check grants and the command issued last cycle.
  task automatic step(
    input logic r0, input logic w0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
    input logic r1, input logic w1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
    input logic e0, input logic e1, input string name);
    rsp_t r;
    @(posedge clk);
    #1;
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    @(negedge clk);
    check({name, ".gnt0"},     32'(bus.gnt0), 32'(e0));
    check({name, ".gnt1"},     32'(bus.gnt1), 32'(e1));
    check({name, ".ram_re"},   32'(bus.ram_re), 32'(pend_re));
    check({name, ".ram_we"},   32'(bus.ram_we), 32'(pend_we));
    check({name, ".ram_addr"}, 32'(bus.ram_addr), 32'(exp_addr));
    check({name, ".ram_wdata"},32'(bus.ram_wdata), 32'(exp_wdata));
    pend_re = (e0 && !w0) || (e1 && !w1);
    pend_we = (e0 && w0) || (e1 && w1);
    if (e0 || e1) begin
      exp_addr  = e1 ? a1 : a0;
      exp_wdata = e1 ? d1 : d0;
      if (pend_we) shadow[exp_addr] = exp_wdata;
      if (pend_re) begin
        r.id   = e1;
        r.data = shadow[exp_addr];
        r.due  = cyc + int'(RD_LATENCY) + 2;
        sbq.push_back(r);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0, 0, 0, "idle");
  endtask

  // Response monitor.
  always @(negedge clk) begin
    rsp_t e;
    if (reset === 1'b1) begin
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        tests++;
        fails++;
        $display("FAIL rsp_missing: got no rvalid, expected id %0d data 0x%0h at cycle %0d",
                 sbq[0].id, sbq[0].data, sbq[0].due);
        void'(sbq.pop_front());
      end
      if (bus.rvalid0 || bus.rvalid1) begin
        check("rvalid_onehot", 32'(bus.rvalid0 & bus.rvalid1), 0);
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL stray_rvalid: got rvalid0=%0d rvalid1=%0d, expected none (cycle %0d)",
                   bus.rvalid0, bus.rvalid1, cyc);
        end else begin
          e = sbq.pop_front();
          check("rsp_cycle", 32'(cyc), 32'(e.due));
          check("rsp_id",    32'(bus.rvalid1), 32'(e.id));
          check("rsp_data",  32'(bus.rdata), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, stray;
    mem[8'h10] <= 24'hAAAAAA;
    mem[8'h20] <= 24'hBBBBBB;
    shadow[8'h10] = 24'hAAAAAA;
    shadow[8'h20] = 24'hBBBBBB;
    pend_re = 1'b0; pend_we = 1'b0; exp_addr = '0; exp_wdata = '0;

    // Reset with both clients requesting: no grants, all outputs clear.
    reset = 1'b0;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h11; bus.wdata0 = 24'h123456;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h22; bus.wdata1 = 24'h654321;
    #12;
    chk_zero("reset");
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // First tie goes to client 0, the next tie from idle to client 1.
    step(1, 1, 8'h40, 24'h111111, 1, 1, 8'h41, 24'h222222, 1, 0, "tie1");
    idle(1);
    step(1, 1, 8'h42, 24'h333333, 1, 1, 8'h41, 24'h222222, 0, 1, "tie2");
    step(1, 1, 8'h42, 24'h333333, 0, 0, '0, '0, 1, 0, "handover");
    idle(1);

    // Single client write then read of the same address.
    step(1, 1, 8'h05, 24'h000001, 0, 0, '0, '0, 1, 0, "wr05");
    step(1, 0, 8'h05, '0,         0, 0, '0, '0, 1, 0, "rd05");
    idle(4);

    // Burst bound: client 0 continuous, client 1 joins at cycle 2.
    n0 = 0; n1 = 0;
    for (int i = 0; i < 12; i++) begin
      logic e0, e1;
      e0 = (i < 4) || (i >= 8);
      e1 = (i >= 4) && (i < 8);
      step(1, 1, 8'(8'h60 + n0), 24'(24'h000100 + n0),
           (i >= 2), 1, 8'(8'h70 + n1), 24'(24'h000200 + n1), e0, e1, "burst");
      if (e0) n0++;
      if (e1) n1++;
    end
    idle(1);

    // Interleaved reads from both clients.
    step(1, 0, 8'h10, '0, 0, 0, '0,    '0, 1, 0, "rd10");
    step(0, 0, '0,    '0, 1, 0, 8'h20, '0, 0, 1, "rd20");
    // Release: back to idle, so the next tie goes to client 0.
    idle(1);
    step(1, 1, 8'h50, 24'h555555, 1, 1, 8'h51, 24'h666666, 1, 0, "tie3");
    step(0, 0, '0,    '0,         1, 1, 8'h51, 24'h666666, 0, 1, "tie3b");
    idle(2);

    // Back-to-back readback by one client (count saturates with the other idle).
    step(1, 0, 8'h60, '0, 0, 0, '0, '0, 1, 0, "rb60");
    step(1, 0, 8'h63, '0, 0, 0, '0, '0, 1, 0, "rb63");
    step(1, 0, 8'h70, '0, 0, 0, '0, '0, 1, 0, "rb70");
    step(1, 0, 8'h40, '0, 0, 0, '0, '0, 1, 0, "rb40");
    step(1, 0, 8'h41, '0, 0, 0, '0, '0, 1, 0, "rb41");
    step(0, 0, '0, '0, 1, 1, 8'h30, 24'hCAFE01, 0, 1, "wr30");
    step(0, 0, '0, '0, 1, 0, 8'h30, '0,         0, 1, "rd30");
    idle(5);

    // Reset mid-burst with reads in flight.
    step(1, 0, 8'h10, '0, 0, 0, '0, '0, 1, 0, "pre_rst0");
    step(1, 0, 8'h20, '0, 0, 0, '0, '0, 1, 0, "pre_rst1");
    step(1, 0, 8'h05, '0, 0, 0, '0, '0, 1, 0, "pre_rst2");
    @(posedge clk);
    #2;
    reset = 1'b0;
    bus.req0 = 1'b0;
    sbq.delete();
    pend_re = 1'b0; pend_we = 1'b0; exp_addr = '0; exp_wdata = '0;
    #1;
    chk_zero("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      stray += int'(bus.rvalid0) + int'(bus.rvalid1);
    end
    check("post_reset_rvalid", 32'(stray), 0);

    // Tie after reset goes to client 0 again.
    step(1, 1, 8'h44, 24'h444444, 1, 0, 8'h20, '0, 1, 0, "tie_rst");
    step(0, 0, '0,    '0,         1, 0, 8'h20, '0, 0, 1, "tie_rst_b");
    idle(5);

    check("sb_empty", 32'(sbq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
